mux_select_sequencer: RTL and testbench
=======================================

Name: mux_select_sequencer

Overview:
Upstream stage of the 7-to-1 select mux. On a start request it captures a 7-bit word and a rate code, then drives the mux select from 0 up to 6, holding each value for a programmable number of clock cycles. It presents the captured word on the mux data inputs and reports busy/done, turning the combinational mux into a timed bit serializer.

Parameters:
CLK_HZ, 50000000, input clock frequency; sets the divider periods.
CNT_WIDTH, 28, divider counter width; must hold 4*CLK_HZ-1.

Ports:
clk  in  1  system clock; all state is on the rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  level-sampled request; acted on in IDLE only
rate  in  2  hold-time code, captured on accepted start
data_in  in  7  word to serialize, captured on accepted start
data_q  out  7  captured word; drives the mux Input
mux_select  out  3  drives the mux MuxSelect
valid  out  1  high while mux_select is being swept (RUN)
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse after select 6 has completed its hold

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (resetn). Asserting resetn=0 at any time, including mid-sweep, forces IDLE.
- Reset values: data_q=0, mux_select=0, valid=0, busy=0, done=0, divider count=0.
- Rate code to period P, where each select value is held for P+1 cycles: 00 -> P=0; 01 -> P=CLK_HZ-1; 10 -> P=2*CLK_HZ-1; 11 -> P=4*CLK_HZ-1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Outputs are valid=0, busy=0, mux_select=0.
  - If start=1 at edge k: capture data_in into data_q and rate into the rate register; load the divider with P; set mux_select=0; move to RUN.
  - valid and busy are high from cycle k+1.
- RUN:
  - Each cycle the divider decrements.
  - When the divider is 0, a tick occurs and the divider reloads P.
  - On a tick with mux_select<6: mux_select increments.
  - On a tick with mux_select==6: go to DONE.
  - Total time in RUN is exactly 7*(P+1) cycles.
  - start is ignored in RUN (base build).
  - data_in and rate changes during RUN have no effect.
- DONE:
  - Lasts exactly one cycle with done=1, busy=1, valid=0, mux_select=0.
  - Next state is IDLE, even if start=1 in this cycle.
  - A start held high is accepted on the first IDLE cycle, so back-to-back sweeps are separated by one IDLE cycle.
- mux_select never takes the value 7.
- data_q holds its value after the sweep until the next accepted start.

Optional Feature:
SEQ_LOOP_EN
- Defined (continuous mode):
  - On the tick at mux_select==6, stay in RUN: mux_select wraps to 0, data_in and rate are re-captured, and the divider loads the new P.
  - done pulses for one cycle coincident with the wrap.
  - start=1 while in RUN stops the sweep: go to DONE, then IDLE.
- Undefined: one-shot behaviour exactly as in Behaviour; start is ignored in RUN.

Decomposition:
- Package mux_seq_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - rate code localparams
  - function mapping rate code to P from CLK_HZ
  - SEL_LAST=3'd6
- Sub-module rate_divider (natural split):
  - inputs: clk, resetn, load, period[CNT_WIDTH-1:0], en
  - output: tick
  - behaviour: loadable down-counter that reloads on zero and asserts tick when the count is 0.
- The FSM, capture registers and select counter stay in mux_select_sequencer.

Test Plan:
- Reset mid-sweep: rate=00, data_in=7'b1010101, start, pull resetn low on cycle 3 -> all outputs 0 immediately (asynchronous), FSM in IDLE.
- Fast sweep: rate=00, data_in=7'b0110011, 1-cycle start -> mux_select is 0,1,...,6 on consecutive cycles with valid=1; done=1 on cycle 8 after start; data_q=7'b0110011 throughout.
- Slow sweep (bench CLK_HZ=4): rate=01 -> each select held 4 cycles, RUN lasts 28 cycles; rate=11 -> each held 16 cycles, RUN lasts 112 cycles.
- Ignore during RUN: change data_in to 7'h7F and pulse start mid-sweep -> data_q and sequence unchanged, no restart; done still at the expected cycle.
- Held start: start tied high, rate=00 -> pattern of 7 RUN cycles, 1 DONE, 1 IDLE, repeating with period 9; mux_select is never 7.
- SEQ_LOOP_EN defined: rate=00, start pulse -> select wraps 6->0 with no gap, done pulses every 7 cycles; new data_in is visible on data_q after the wrap; start pulse in RUN -> DONE then IDLE.

Source files
------------

// File: rtl/mux_select_sequencer_pkg.sv
// Shared types and helpers for the mux select sequencer: state encoding,
// rate codes and the rate-code-to-divider-period mapping.
package mux_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] RATE_FAST = 2'b00;
  localparam logic [1:0] RATE_1X   = 2'b01;
  localparam logic [1:0] RATE_2X   = 2'b10;
  localparam logic [1:0] RATE_4X   = 2'b11;

  localparam logic [2:0] SEL_LAST = 3'd6;

  // Divider reload value; each select value is held for period+1 cycles.
  function automatic logic [31:0] rate_to_period(input logic [1:0] code,
                                                 input logic [31:0] clk_hz);
    logic [31:0] p;
    case (code)
      RATE_FAST: p = 32'd0;
      RATE_1X:   p = clk_hz - 32'd1;
      RATE_2X:   p = (clk_hz << 1) - 32'd1;
      RATE_4X:   p = (clk_hz << 2) - 32'd1;
      default:   p = 32'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mux_select_sequencer_if.sv
// Request/status bundle between the sequencer (slave) and its controller (master).
interface mux_select_sequencer_if;
  logic       start;
  logic [1:0] rate;
  logic [6:0] data_in;
  logic [6:0] data_q;
  logic [2:0] mux_select;
  logic       valid;
  logic       busy;
  logic       done;

  modport master (
    output start, rate, data_in,
    input  data_q, mux_select, valid, busy, done
  );

  modport slave (
    input  start, rate, data_in,
    output data_q, mux_select, valid, busy, done
  );
endinterface

// File: rtl/mux_select_sequencer_rate_divider.sv
// Loadable down-counter: reloads the period on reaching zero and flags a tick
// on every enabled cycle where the count is zero.
module rate_divider #(
  parameter int unsigned CNT_WIDTH = 28
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic                 en,
  output logic                 tick
);

  logic [CNT_WIDTH-1:0] cnt_q;

  assign tick = en && (cnt_q == {CNT_WIDTH{1'b0}});

  // Count down while enabled; load has priority over the wrap reload.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else if (load) begin
      cnt_q <= period;
    end else if (en) begin
      if (cnt_q == {CNT_WIDTH{1'b0}}) begin
        cnt_q <= period;
      end else begin
        cnt_q <= cnt_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Timed sweep of a 7-to-1 mux select over a captured word.
// Optional continuous mode: define SEQ_LOOP_EN.
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 32'd50_000_000,
  parameter int unsigned CNT_WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  resetn,
  mux_select_sequencer_if.slave bus
);

  state_e               state_q;
  logic [6:0]           word_q;
  logic [1:0]           rate_q;
  logic [2:0]           sel_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 load_s;
  logic                 en_s;
  logic                 tick_s;
  logic                 last_tick_s;
  logic [CNT_WIDTH-1:0] period_s;

  // Divider control: a fresh load always uses the live rate input.
  always_comb begin
    en_s        = (state_q == ST_RUN);
    last_tick_s = en_s && tick_s && (sel_q == SEL_LAST);
`ifdef SEQ_LOOP_EN
    load_s = ((state_q == ST_IDLE) && bus.start) || (last_tick_s && !bus.start);
`else
    load_s = (state_q == ST_IDLE) && bus.start;
`endif
    if (load_s) begin
      period_s = CNT_WIDTH'(rate_to_period(bus.rate, 32'(CLK_HZ)));
    end else begin
      period_s = CNT_WIDTH'(rate_to_period(rate_q, 32'(CLK_HZ)));
    end
  end

  rate_divider #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_div (
    .clk    (clk),
    .resetn (resetn),
    .load   (load_s),
    .period (period_s),
    .en     (en_s),
    .tick   (tick_s)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      word_q  <= 7'd0;
      rate_q  <= 2'd0;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sel_q  <= 3'd0;
          done_q <= 1'b0;
          if (bus.start) begin
            word_q  <= bus.data_in;
            rate_q  <= bus.rate;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          done_q <= 1'b0;
`ifdef SEQ_LOOP_EN
          if (bus.start) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            valid_q <= 1'b0;
            sel_q   <= 3'd0;
          end else if (tick_s) begin
            if (sel_q == SEL_LAST) begin
              sel_q  <= 3'd0;
              done_q <= 1'b1;
              word_q <= bus.data_in;
              rate_q <= bus.rate;
            end else begin
              sel_q <= sel_q + 3'd1;
            end
          end
`else
          if (tick_s) begin
            if (sel_q == SEL_LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              valid_q <= 1'b0;
              sel_q   <= 3'd0;
            end else begin
              sel_q <= sel_q + 3'd1;
            end
          end
`endif
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          sel_q   <= 3'd0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          sel_q   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.data_q     = word_q;
  assign bus.mux_select = sel_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Randomized directed bench for mux_select_sequencer with a schedule-based
// reference model (expected outputs derived from cycle offset after start).
module tb_mux_select_sequencer;

  localparam int CLK_HZ    = 4;
  localparam int CNT_WIDTH = 5;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  mux_select_sequencer_if bus ();

  mux_select_sequencer #(
    .CLK_HZ    (CLK_HZ),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int t, input logic [2:0] sel,
                         input logic v, input logic b, input logic d, input logic [6:0] dq);
    chk($sformatf("%s t=%0d mux_select", tag, t), 32'(bus.mux_select), 32'(sel));
    chk($sformatf("%s t=%0d valid", tag, t), 32'(bus.valid), 32'(v));
    chk($sformatf("%s t=%0d busy", tag, t), 32'(bus.busy), 32'(b));
    chk($sformatf("%s t=%0d done", tag, t), 32'(bus.done), 32'(d));
    chk($sformatf("%s t=%0d data_q", tag, t), 32'(bus.data_q), 32'(dq));
  endtask

  // Cycles each select value is held for a rate code.
  function automatic int hold_of(input logic [1:0] code);
    if (code == 2'd0) return 1;
    else return CLK_HZ << (code - 2'd1);
  endfunction

  // Expected outputs t cycles after the accepting edge of a one-shot sweep.
  function automatic void model(input int t, input int h, output logic [2:0] sel,
                                output logic v, output logic b, output logic d);
    if (t >= 1 && t <= 7 * h) begin
      sel = 3'((t - 1) / h); v = 1'b1; b = 1'b1; d = 1'b0;
    end else if (t == 7 * h + 1) begin
      sel = 3'd0; v = 1'b0; b = 1'b1; d = 1'b1;
    end else begin
      sel = 3'd0; v = 1'b0; b = 1'b0; d = 1'b0;
    end
  endfunction

  task automatic sweep(input string tag, input logic [1:0] code, input logic [6:0] word,
                       input bit disturb);
    int h;
    logic [2:0] es;
    logic ev, eb, ed;
    h = hold_of(code);
    @(negedge clk);
    bus.rate = code; bus.data_in = word; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 1; t <= 7 * h + 2; t++) begin
      if (t > 1) @(negedge clk);
      model(t, h, es, ev, eb, ed);
      chk_all(tag, t, es, ev, eb, ed, word);
      bus.data_in = disturb ? 7'h7F : 7'($urandom);
      bus.rate    = 2'($urandom);
      bus.start   = (disturb && t == 3) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] drv, last, exp_data, d0, d1;
    logic [2:0] es;
    logic ev, eb, ed;
    bus.start = 1'b0; bus.rate = 2'd0; bus.data_in = 7'd0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 3'd0, 1'b0, 1'b0, 1'b0, 7'd0);
    resetn = 1'b1;

    // Reset mid-sweep: outputs must clear without waiting for a clock edge.
    @(negedge clk);
    bus.rate = 2'b00; bus.data_in = 7'b1010101; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("pre_rst", 3, 3'd2, 1'b1, 1'b1, 1'b0, 7'b1010101);
    #2 resetn = 1'b0;
    #1 chk_all("async_rst", 3, 3'd0, 1'b0, 1'b0, 1'b0, 7'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk_all("post_rst_idle", 0, 3'd0, 1'b0, 1'b0, 1'b0, 7'd0);

`ifndef SEQ_LOOP_EN
    sweep("fast", 2'b00, 7'b0110011, 1'b0);
    sweep("rate01", 2'b01, 7'($urandom), 1'b0);
    sweep("rate11", 2'b11, 7'($urandom), 1'b0);
    sweep("rate10", 2'b10, 7'($urandom), 1'b0);
    sweep("ignore00", 2'b00, 7'($urandom), 1'b1);
    sweep("ignore01", 2'b01, 7'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) sweep("rand", 2'($urandom_range(0, 2)), 7'($urandom), 1'b0);

    // Held start: 7 RUN, 1 DONE, 1 IDLE, repeating every 9 cycles.
    @(negedge clk);
    drv = 7'($urandom);
    exp_data = 7'd0;
    bus.rate = 2'b00; bus.data_in = drv; bus.start = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      last = drv;
      @(negedge clk);
      if ((c - 1) % 9 == 0) exp_data = last;
      model(((c - 1) % 9) + 1, 1, es, ev, eb, ed);
      chk_all("held", c, es, ev, eb, ed, exp_data);
      drv = 7'($urandom);
      bus.data_in = drv;
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
`else
    // Continuous mode: wrap without a gap, recapture at the wrap, start stops.
    d0 = 7'($urandom);
    d1 = ~d0;
    @(negedge clk);
    bus.rate = 2'b00; bus.data_in = d0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.data_in = d1;
    for (int t = 1; t <= 12; t++) begin
      if (t > 1) @(negedge clk);
      if (t <= 10) chk_all("loop", t, 3'((t - 1) % 7), 1'b1, 1'b1, (t == 8), (t < 8) ? d0 : d1);
      else if (t == 11) chk_all("loop", t, 3'd0, 1'b0, 1'b1, 1'b1, d1);
      else chk_all("loop", t, 3'd0, 1'b0, 1'b0, 1'b0, d1);
      bus.start = (t == 10) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
